// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: LANES-wide AES SubBytes behind an elastic valid/ready pipe.
// Optional inverse S-box per beat when SUB_BYTES_INV_SBOX_EN is defined.
module sub_bytes_pipe #(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_inv,
    output logic [2:0]           occupancy
);

    localparam int DW = 8 * LANES;

    // Byte b of the table lives at bits [8*(255-b) +: 8] (first row is MSB).
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_lut(input logic [7:0] b);
        return SBOX_FWD[8*(255-int'(b)) +: 8];
    endfunction

`ifdef SUB_BYTES_INV_SBOX_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_lut(input logic [7:0] b);
        return SBOX_INV[8*(255-int'(b)) +: 8];
    endfunction
`endif

    logic [PIPE_STAGES-1:0] v_q;
    logic [PIPE_STAGES-1:0] v_d;
    logic [PIPE_STAGES-1:0] inv_q;
    logic [PIPE_STAGES-1:0] inv_d;
    logic [DW-1:0]          data_q [PIPE_STAGES];
    logic [DW-1:0]          data_d [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];

    logic [PIPE_STAGES:0]   rdy;
    logic [DW-1:0]          sub_data;
    logic                   mode_in;
    logic [2:0]             occ;

`ifdef SUB_BYTES_INV_SBOX_EN
    assign mode_in = in_inv;
`else
    // Forward-only build: the mode input has no effect on the datapath.
    logic unused_inv;
    assign unused_inv = in_inv;
    assign mode_in    = 1'b0;
`endif

    // Independent per-lane table lookup ahead of the stage-1 registers
    always_comb begin
        sub_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SUB_BYTES_INV_SBOX_EN
            sub_data[8*i +: 8] = in_inv ? inv_lut(in_data[8*i +: 8])
                                        : fwd_lut(in_data[8*i +: 8]);
`else
            sub_data[8*i +: 8] = fwd_lut(in_data[8*i +: 8]);
`endif
        end
    end

    // Ready ripples back from out_ready; an empty stage is always ready
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        rdy[PIPE_STAGES] = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            r      = !v_q[k] || r;
            rdy[k] = r;
        end
    end

    // Each ready stage takes whatever its upstream neighbour holds
    always_comb begin
        v_d    = v_q;
        inv_d  = inv_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (rdy[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = sub_data;
                tag_d[0]  = in_tag;
                inv_d[0]  = mode_in;
            end
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                    inv_d[k]  = inv_q[k-1];
                end
            end
        end
    end

    // Stage registers; reset empties the pipe and clears its payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            inv_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            v_q    <= v_d;
            inv_q  <= inv_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    // Count of valid stages
    always_comb begin
        occ = 3'd0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            occ = occ + {2'b00, v_q[k]};
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign out_tag   = tag_q[PIPE_STAGES-1];
    assign out_inv   = inv_q[PIPE_STAGES-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb_sub_bytes_pipe: scenario tasks against a GF(2^8)-derived S-box model.
// Inverse-mode expectations follow SUB_BYTES_INV_SBOX_EN.
module tb_sub_bytes_pipe;

    localparam int LANES = 16;
    localparam int PS    = 2;
    localparam int TAG_W = 4;
    localparam int DW    = 8 * LANES;
    localparam int NRAND = 1000;
`ifdef SUB_BYTES_INV_SBOX_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [TAG_W-1:0] in_tag;
    logic             in_inv;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_inv;
    logic [2:0]       occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             inv;
    } beat_t;

    sub_bytes_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_inv(out_inv),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic build_model();
        logic [7:0] iv, s;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = (INV_EN && inv) ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = rand_data();
        in_tag = 4'hA; in_inv = 1'b1; out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        n_checks++; if (out_inv !== 1'b0) begin n_fail++; $display("FAIL reset_out_inv got %b want 0", out_inv); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_ignored_valid occupancy got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_latency();
        logic [DW-1:0] exp_d;
        exp_d = {LANES{8'h63}};
        in_data = '0; in_tag = 4'd5; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= PS; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== (c == PS)) begin
                n_fail++; $display("FAIL lat_out_valid cycle %0d got %b want %b", c, out_valid, (c == PS));
            end
            if (c < PS) tick();
        end
        n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL lat_out_data got %h want %h", out_data, exp_d); end
        n_checks++; if (out_tag !== 4'd5) begin n_fail++; $display("FAIL lat_out_tag got %h want 5", out_tag); end
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drained got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_stream_all();
        int nout;
        bit started;
        logic [DW-1:0] src, exp_d;
        nout = 0; started = 1'b0;
        out_ready = 1'b1; in_inv = 1'b0;
        for (int j = 0; j < 16 + PS + 4 && nout < 16; j++) begin
            if (j < 16) begin
                for (int i = 0; i < LANES; i++) in_data[8*i +: 8] = 8'(16*j + i);
                in_tag = TAG_W'(j); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j < 16) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready beat %0d got %b want 1", j, in_ready); end
            end
            if (out_valid) begin
                for (int i = 0; i < LANES; i++) src[8*i +: 8] = 8'(16*nout + i);
                exp_d = model_beat(src, 1'b0);
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL stream_data beat %0d got %h want %h", nout, out_data, exp_d); end
                n_checks++; if (out_tag !== TAG_W'(nout)) begin n_fail++; $display("FAIL stream_tag beat %0d got %h want %h", nout, out_tag, TAG_W'(nout)); end
                if (nout == 0) begin
                    n_checks++; if (out_data[7:0] !== 8'h63) begin n_fail++; $display("FAIL stream_00 got %h want 63", out_data[7:0]); end
                end
                if (nout == 5) begin
                    n_checks++; if (out_data[31:24] !== 8'hED) begin n_fail++; $display("FAIL stream_53 got %h want ed", out_data[31:24]); end
                end
                if (nout == 15) begin
                    n_checks++; if (out_data[127:120] !== 8'h16) begin n_fail++; $display("FAIL stream_ff got %h want 16", out_data[127:120]); end
                end
                started = 1'b1;
                nout++;
            end else if (started) begin
                n_checks++; n_fail++;
                $display("FAIL stream_gap after beat %0d got out_valid 0 want 1", nout);
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (nout != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", nout); end
    endtask

    task automatic test_stall();
        logic [DW-1:0]    bd [3];
        logic [TAG_W-1:0] bt [3];
        logic [DW-1:0]    exp_d;
        int nout;
        bit acc;
        for (int b = 0; b < 3; b++) begin
            bd[b] = rand_data(); bt[b] = TAG_W'(b + 9);
        end
        out_ready = 1'b0; in_inv = 1'b0;
        in_valid = 1'b1; in_data = bd[0]; in_tag = bt[0];
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_accept %0d in_ready got %b want 1", c, in_ready); end
            tick();
            in_data = bd[c+1]; in_tag = bt[c+1];
        end
        exp_d = model_beat(bd[0], 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full in_ready got %b want 0", in_ready); end
            n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL stall_occupancy got %0d want 2", occupancy); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got %b want 1", out_valid); end
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL stall_hold_data got %h want %h", out_data, exp_d); end
            n_checks++; if (out_tag !== bt[0]) begin n_fail++; $display("FAIL stall_hold_tag got %h want %h", out_tag, bt[0]); end
            tick();
        end
        out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 8 && nout < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_d = model_beat(bd[nout], 1'b0);
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL stall_drain_data beat %0d got %h want %h", nout, out_data, exp_d); end
                n_checks++; if (out_tag !== bt[nout]) begin n_fail++; $display("FAIL stall_drain_tag beat %0d got %h want %h", nout, out_tag, bt[nout]); end
                nout++;
            end else begin
                n_checks++; n_fail++;
                $display("FAIL stall_drain_gap at beat %0d got out_valid 0 want 1", nout);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++; if (nout != 3) begin n_fail++; $display("FAIL stall_drain_count got %0d want 3", nout); end
    endtask

    task automatic test_random_stream();
        beat_t q[$];
        beat_t e;
        beat_t held_b;
        bit held, acc;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        while (got < NRAND && cyc < 20000) begin
            if (!in_valid && sent < NRAND && $urandom_range(0, 9) != 0) begin
                in_data = rand_data(); in_tag = TAG_W'($urandom_range(0, 15));
                in_inv = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (occupancy !== 3'(q.size())) begin
                n_fail++; $display("FAIL rand_occupancy cycle %0d got %0d want %0d", cyc, occupancy, q.size());
            end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_b.data ||
                    out_tag !== held_b.tag || out_inv !== held_b.inv) begin
                    n_fail++; $display("FAIL rand_stable cycle %0d got %b/%h want 1/%h", cyc, out_valid, out_data, held_b.data);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                e.data = model_beat(in_data, in_inv);
                e.tag  = in_tag;
                e.inv  = INV_EN ? in_inv : 1'b0;
                q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious cycle %0d got beat %h want none", cyc, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.data || out_tag !== e.tag || out_inv !== e.inv) begin
                        n_fail++; $display("FAIL rand_beat %0d got %h/%h/%b want %h/%h/%b", got, out_data, out_tag, out_inv, e.data, e.tag, e.inv);
                    end
                end
                got++;
            end
            held = out_valid && !out_ready;
            held_b.data = out_data; held_b.tag = out_tag; held_b.inv = out_inv;
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got != NRAND) begin n_fail++; $display("FAIL rand_timeout got %0d beats want %0d", got, NRAND); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover got %0d want 0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_inv = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; in_data = rand_data(); in_tag = TAG_W'(b + 1);
            tick();
        end
        in_data = rand_data();
        out_ready = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL midrst_occupancy got %0d want 0", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_out_data got %h want 0", out_data); end
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost cycle %0d got %b want 0", c, out_valid); end
            tick();
        end
    endtask

    task automatic test_inv();
        logic [DW-1:0] di [2];
        logic          ii [2];
        logic [DW-1:0] eo [2];
        logic          ei [2];
        int nexp, nout;
`ifdef SUB_BYTES_INV_SBOX_EN
        nexp = 2;
        di[0] = {LANES{8'hED}}; ii[0] = 1'b1; eo[0] = {LANES{8'h53}}; ei[0] = 1'b1;
        di[1] = {LANES{8'h53}}; ii[1] = 1'b0; eo[1] = {LANES{8'hED}}; ei[1] = 1'b0;
`else
        nexp = 1;
        di[0] = {LANES{8'h63}}; ii[0] = 1'b1; eo[0] = {LANES{8'hFB}}; ei[0] = 1'b0;
        di[1] = '0; ii[1] = 1'b0; eo[1] = '0; ei[1] = 1'b0;
`endif
        out_ready = 1'b1; nout = 0;
        for (int j = 0; j < 10 && nout < nexp; j++) begin
            if (j < nexp) begin
                in_valid = 1'b1; in_data = di[j]; in_inv = ii[j]; in_tag = TAG_W'(j);
            end else begin
                in_valid = 1'b0; in_inv = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                n_checks++; if (out_data !== eo[nout]) begin n_fail++; $display("FAIL inv_data beat %0d got %h want %h", nout, out_data, eo[nout]); end
                n_checks++; if (out_inv !== ei[nout]) begin n_fail++; $display("FAIL inv_mode beat %0d got %b want %b", nout, out_inv, ei[nout]); end
                nout++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (nout != nexp) begin n_fail++; $display("FAIL inv_count got %0d want %0d", nout, nexp); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0;
        in_inv = 1'b0; out_ready = 1'b0;
        build_model();
        tick();
        test_reset();
        test_latency();
        test_stream_all();
        test_stall();
        test_random_stream();
        test_reset_midflight();
        test_inv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_bytes_pipe.md
Name: sub_bytes_pipe

Overview:
- Parametrised, pipelined multi-lane AES SubBytes unit; successor to the single-byte combinational S-box.
- Substitutes LANES bytes per beat through independent standard FIPS-197 forward S-box lookups.
- Uses a valid/ready elastic pipeline with per-stage valid bits and full throughput.
- Sits between the round-key XOR stage and ShiftRows in the round datapath; also used by key expansion with LANES=4.

Parameters:
- LANES, 16, bytes substituted per beat (1..16); 16 = full AES state, 4 = key-schedule word.
- PIPE_STAGES, 2, register stages from input to output (1..4); also the latency in cycles.
- TAG_W, 4, width of a sideband tag carried alongside the data unchanged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  8*LANES  input bytes; lane i = in_data[8*i+7:8*i].
- in_tag  in  TAG_W  sideband tag.
- in_inv  in  1  inverse-S-box select per beat; see Optional Feature.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  8*LANES  substituted bytes, same lane mapping as in_data.
- out_tag  out  TAG_W  tag of the beat.
- out_inv  out  1  mode the beat was processed with.
- occupancy  out  3  number of valid beats in flight (0..PIPE_STAGES).

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_data, in_tag and in_inv are sampled only on an input transfer.
- Lookup:
  - Combinational per lane, between the inputs and stage-1 registers.
  - Lanes are fully independent; no cross-lane arithmetic.
  - Stages 2..PIPE_STAGES are pure registers carrying data, tag, mode and valid.
- Stage control:
  - Each stage k holds v_k.
  - ready_k = !v_k || ready_(k+1), with ready_(PIPE_STAGES+1) = out_ready.
  - Stage k loads from stage k-1 when ready_k is high.
  - in_ready = ready_1. This is combinational from out_ready through the chain; accepted.
- Timing:
  - Latency is exactly PIPE_STAGES cycles with no stall.
  - Throughput is 1 beat/cycle while out_ready is held high.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Stall: when out_ready is low, out_valid, out_data, out_tag and out_inv hold stable until the transfer. No beat is lost or duplicated.
- occupancy = sum of v_k; updates the cycle after each transfer.
- Full/empty:
  - Full: occupancy = PIPE_STAGES.
  - With out_ready low and the pipe full, in_ready = 0.
  - With out_ready high and the pipe full, in_ready = 1 and input/output transfers occur in the same cycle; occupancy is unchanged.
  - Empty: out_valid = 0.
- Reset (rst_n low at a clk edge):
  - All v_k = 0; data, tag and mode registers = 0.
  - Outputs: out_valid=0, out_data=0, out_tag=0, out_inv=0, occupancy=0, in_ready=1 from the cycle after reset.
  - Reset mid-operation discards all in-flight beats.
  - in_valid is ignored while rst_n is low.
- The forward table is the FIPS-197 S-box, e.g. 00->63, 01->7C, 53->ED, FF->16.

Optional Feature:
- Macro: SUB_BYTES_INV_SBOX_EN.
- Defined:
  - A second per-lane table (FIPS-197 inverse S-box) is instantiated.
  - in_inv=1 selects the inverse lookup for that beat; in_inv=0 selects forward.
  - The mode is carried through the pipeline and presented on out_inv.
  - Mixed-mode beats back-to-back are legal.
- Not defined:
  - in_inv is ignored; all beats use the forward table.
  - out_inv is tied to 0; no inverse table is synthesised.

Test Plan:
- LANES=16, PIPE_STAGES=2: beat with all lanes 00, tag 5 -> out_valid exactly 2 cycles later; all lanes 63, out_tag=5.
- Stream all 256 byte values (16 beats, bytes 00..FF ascending), out_ready=1 -> 16 consecutive output beats, one per cycle, matching the FIPS table (00->63, 53->ED, FF->16).
- Hold out_ready=0 and send 3 beats -> 2 accepted, occupancy=2, in_ready=0, outputs stable. Release out_ready -> all 3 beats emerge in order, no gaps after the first.
- Toggle out_ready randomly with a continuous stream of 1000 beats -> scoreboard shows no loss, duplication or reorder; out_data is stable while out_valid && !out_ready.
- Assert rst_n=0 for 1 cycle with 2 beats in flight -> next cycle out_valid=0, occupancy=0, in_ready=1; the discarded beats never appear.
- With SUB_BYTES_INV_SBOX_EN: beat ED (in_inv=1) followed by 53 (in_inv=0) -> outputs 53 with out_inv=1, then ED with out_inv=0.
- Without SUB_BYTES_INV_SBOX_EN: beat 63 with in_inv=1 -> output FB, out_inv=0.
